// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven instruction source for simple_cpu.
// Holds a loadable program memory and presents one word at a time. Each word
// is held for the number of clocks its class needs in the control unit.
// Class 00 words act as HALT.
// Optional feature macro: IFETCH_LOOP_EN (wrap from the last address back to 0
// and keep running instead of halting).
module instr_fetch #(
  parameter int INSTR_WIDTH  = 20,
  parameter int PC_BITS      = 5,
  parameter int STD_CYCLES   = 3,
  parameter int LOAD_CYCLES  = 4,
  parameter int STORE_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PC_BITS-1:0]     load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   halted,
  output logic                   retire
);

  localparam int DEPTH = 2**PC_BITS;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic [PC_BITS-1:0]     nxt_pc;
  logic [INSTR_WIDTH-1:0] nxt_word;
  logic [INSTR_WIDTH-1:0] first_word;

  function automatic logic [1:0] cls_of(input logic [INSTR_WIDTH-1:0] w);
    return w[INSTR_WIDTH-1 -: 2];
  endfunction

  // Number of control-unit cycles the word must be held for.
  function automatic logic [CNT_W-1:0] cycles(input logic [1:0] cls);
    case (cls)
      2'b01:   return CNT_W'(STD_CYCLES);
      2'b10:   return CNT_W'(LOAD_CYCLES);
      2'b11:   return CNT_W'(STORE_CYCLES);
      default: return '0;
    endcase
  endfunction

  // Next fetch address wraps naturally at the top of memory.
  always_comb begin
    nxt_pc     = pc + PC_BITS'(1);
    nxt_word   = mem[nxt_pc];
    first_word = mem[0];
  end

  // Program memory: writable only outside RUN, never reset.
  always_ff @(posedge clk) begin
    if (load_en && state != S_RUN) mem[load_addr] <= load_data;
  end

  // Fetch sequencer: start, hold countdown, advance and halt detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      instruction <= '0;
      pc          <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          // A write in the same cycle wins; start is dropped.
          if (start && !load_en) begin
            pc <= '0;
            if (cls_of(first_word) == 2'b00) begin
              state       <= S_HALT;
              instruction <= '0;
              cnt         <= '0;
            end else begin
              // Full class count (not count-1): the extra edge covers the
              // CU's RESET-to-DECODE transition on the first word only.
              state       <= S_RUN;
              instruction <= first_word;
              cnt         <= cycles(cls_of(first_word));
            end
          end
        end
        S_RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
`ifndef IFETCH_LOOP_EN
            if (pc == PC_BITS'(DEPTH - 1)) begin
              state       <= S_HALT;
              instruction <= '0;
              pc          <= '0;
              cnt         <= '0;
            end else
`endif
            if (cls_of(nxt_word) == 2'b00) begin
              state       <= S_HALT;
              instruction <= '0;
              pc          <= nxt_pc;
              cnt         <= '0;
            end else begin
              instruction <= nxt_word;
              pc          <= nxt_pc;
              cnt         <= cycles(cls_of(nxt_word)) - CNT_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status flags decoded straight from registered state.
  always_comb begin
    busy   = (state == S_RUN);
    halted = (state == S_HALT);
    retire = busy && (cnt == '0);
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [19:0] load_data;
  logic        start;
  logic [19:0] instruction;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;
  logic        retire;

  int checks;
  int errors;

  instr_fetch dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .instruction(instruction),
    .pc(pc), .busy(busy), .halted(halted), .retire(retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [4:0] a, input logic [19:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
    #12;
    checks++;
    if (instruction !== 20'h0 || pc !== 5'd0 || busy !== 1'b0 || halted !== 1'b0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: instr=%h pc=%0d busy=%b halted=%b retire=%b, want all 0", instruction, pc, busy, halted, retire);
    end
    rst = 1'b0;
    tick();
    load_word(5'd0, 20'h52000);
    load_word(5'd1, 20'h98010);
    load_word(5'd2, 20'h00000);
    do_start();
    tick(); tick(); tick(); tick(); // now in mem[1] window
    #2 rst = 1'b1;
    #1;
    checks++;
    if (instruction !== 20'h0 || pc !== 5'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: instr=%h pc=%0d busy=%b, want 0/0/0", instruction, pc, busy);
    end
    #2 rst = 1'b0;
    tick();
    do_start();
    checks++;
    if (instruction !== 20'h52000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mem_kept: instr=%h busy=%b, want 52000/1", instruction, busy);
    end
    do_reset();
  endtask

  task automatic test_std_load_halt();
    do_start(); // edge T0
    checks++;
    if (instruction !== 20'h52000 || pc !== 5'd0 || busy !== 1'b1 || retire !== 1'b0) begin
      errors++;
      $display("FAIL std_t0: instr=%h pc=%0d busy=%b retire=%b, want 52000/0/1/0", instruction, pc, busy, retire);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (instruction !== 20'h52000 || pc !== 5'd0 || retire !== (i == 3)) begin
        errors++;
        $display("FAIL std_hold_T%0d: instr=%h pc=%0d retire=%b, want 52000/0/%b", i, instruction, pc, retire, (i == 3));
      end
    end
    tick(); // T4
    checks++;
    if (instruction !== 20'h98010 || pc !== 5'd1 || retire !== 1'b0) begin
      errors++;
      $display("FAIL load_T4: instr=%h pc=%0d retire=%b, want 98010/1/0", instruction, pc, retire);
    end
    for (int i = 5; i <= 7; i++) begin
      tick();
      checks++;
      if (instruction !== 20'h98010 || pc !== 5'd1 || retire !== (i == 7)) begin
        errors++;
        $display("FAIL load_hold_T%0d: instr=%h pc=%0d retire=%b, want 98010/1/%b", i, instruction, pc, retire, (i == 7));
      end
    end
    tick(); // T8
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || instruction !== 20'h0 || pc !== 5'd2 || retire !== 1'b0) begin
      errors++;
      $display("FAIL halt_T8: halted=%b busy=%b instr=%h pc=%0d retire=%b, want 1/0/0/2/0", halted, busy, instruction, pc, retire);
    end
  endtask

  task automatic test_store_hold();
    int held, pulses;
    held = 0; pulses = 0;
    load_word(5'd1, 20'hC4010);
    do_start();
    for (int i = 0; i < 15; i++) begin
      if (instruction === 20'hC4010) held++;
      if (retire === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (held !== 3) begin
      errors++;
      $display("FAIL store_held: got %0d edges, want 3", held);
    end
    checks++;
    if (pulses !== 2 || halted !== 1'b1 || pc !== 5'd2) begin
      errors++;
      $display("FAIL store_retire: pulses=%0d halted=%b pc=%0d, want 2/1/2", pulses, halted, pc);
    end
  endtask

  task automatic test_ignored_inputs();
    bit ok;
    load_word(5'd1, 20'h98010);
    do_start(); // T0
    tick();     // T1
    load_en = 1'b1; load_addr = 5'd1; load_data = 20'h44444; start = 1'b1;
    tick();     // T2
    load_en = 1'b0; start = 1'b0;
    checks++;
    if (pc !== 5'd0 || instruction !== 20'h52000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ign_start_run: pc=%0d instr=%h busy=%b, want 0/52000/1", pc, instruction, busy);
    end
    tick(); tick(); // T3, T4
    checks++;
    if (instruction !== 20'h98010 || pc !== 5'd1) begin
      errors++;
      $display("FAIL ign_load_run: instr=%h pc=%0d, want 98010/1", instruction, pc);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (halted === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ign_halt_timeout: halted=%b, want 1", halted);
    end
    do_reset();
    // start together with a write in IDLE: write wins, stays IDLE
    load_en = 1'b1; load_addr = 5'd0; load_data = 20'h00000; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || halted !== 1'b0 || instruction !== 20'h0) begin
      errors++;
      $display("FAIL ign_start_idle: busy=%b halted=%b instr=%h, want 0/0/0", busy, halted, instruction);
    end
    // the written class-00 word at address 0 halts immediately
    do_start();
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || instruction !== 20'h0 || pc !== 5'd0) begin
      errors++;
      $display("FAIL halt_at_0: halted=%b busy=%b instr=%h pc=%0d, want 1/0/0/0", halted, busy, instruction, pc);
    end
  endtask

  task automatic test_full_memory();
    int retires;
    bit ok;
    for (int a = 0; a < 32; a++) load_word(5'(a), 20'h52000);
    do_start();
    retires = 0;
`ifndef IFETCH_LOOP_EN
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (retire === 1'b1) retires++;
      tick();
      if (halted === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok || retires !== 32 || pc !== 5'd0 || instruction !== 20'h0) begin
      errors++;
      $display("FAIL full_halt: halted=%b retires=%0d pc=%0d instr=%h, want 1/32/0/0", ok, retires, pc, instruction);
    end
`else
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (pc === 5'd31) ok = 1'b1;
    end
    for (int i = 0; i < 10 && ok && pc !== 5'd0; i++) tick();
    checks++;
    if (!ok || pc !== 5'd0 || busy !== 1'b1 || instruction !== 20'h52000) begin
      errors++;
      $display("FAIL full_wrap: reached31=%b pc=%0d busy=%b instr=%h, want 1/0/1/52000", ok, pc, busy, instruction);
    end
    // wrapped word 0 has no extra first-word cycle
    for (int i = 0; i < 10 && pc === 5'd0; i++) begin
      tick();
      retires++;
    end
    checks++;
    if (retires !== 3 || pc !== 5'd1) begin
      errors++;
      $display("FAIL wrap_hold: got %0d edges pc=%0d, want 3/1", retires, pc);
    end
`endif
    do_reset();
  endtask

  task automatic test_restart();
    bit ok;
    load_word(5'd1, 20'h00000);
    do_start();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (halted === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok || pc !== 5'd1) begin
      errors++;
      $display("FAIL restart_first_halt: halted=%b pc=%0d, want 1/1", ok, pc);
    end
    do_start();
    checks++;
    if (pc !== 5'd0 || instruction !== 20'h52000 || busy !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL restart_t0: pc=%0d instr=%h busy=%b halted=%b, want 0/52000/1/0", pc, instruction, busy, halted);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (instruction !== 20'h52000 || retire !== (i == 3)) begin
        errors++;
        $display("FAIL restart_hold_T%0d: instr=%h retire=%b, want 52000/%b", i, instruction, retire, (i == 3));
      end
    end
    tick();
    checks++;
    if (halted !== 1'b1 || pc !== 5'd1 || instruction !== 20'h0) begin
      errors++;
      $display("FAIL restart_halt: halted=%b pc=%0d instr=%h, want 1/1/0", halted, pc, instruction);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_std_load_halt();
    test_store_hold();
    test_ignored_inputs();
    test_full_memory();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
